// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-client round-robin controller of the 16x8 RAM.
package ram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    RESP  = 3'd2,
    DONE  = 3'd3,
    CLEAR = 3'd4
  } arb_state_e;

  localparam logic [3:0] CS_SEL    = 4'hF;
  localparam logic [3:0] CS_OFF    = 4'h0;
  localparam int         RAM_WORDS = 16;
  localparam int         NUM_REQ   = 2;

endpackage

// File: rtl/ram_rr_picker.sv
// Two-way round-robin picker: combinational grant from the request pair plus a
// favourite pointer that flips only when a contested round is granted.
module ram_rr_picker
  import ram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_grant_stb,
  output logic               o_grant_valid,
  output logic               o_grant_idx
);

  // Client that wins the next round in which both clients are requesting.
  logic r_favour;

  always_comb begin
    o_grant_valid = |i_req;
    o_grant_idx   = 1'b0;
    if (&i_req) begin
      o_grant_idx = r_favour;
    end else if (i_req[1]) begin
      o_grant_idx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_favour <= 1'b0;
    end else if (i_grant_stb && (&i_req)) begin
      r_favour <= ~o_grant_idx;
    end
  end

endmodule

// File: rtl/ram_w16b8_arbiter.sv
// Round-robin req/ack controller serialising two clients onto the 16x8 RAM port.
// Optional RAM_INIT_CLEAR_EN adds a post-reset CLEAR pass that zeroes all 16 words.
module ram_w16b8_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AddressDepth = 4,
  parameter int DataWide     = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              we,
  input  logic [NUM_REQ*AddressDepth-1:0] addr,
  input  logic [NUM_REQ*DataWide-1:0]     wdata,
  output logic [NUM_REQ-1:0]              ack,
  output logic [DataWide-1:0]             rdata,
  output logic                            busy,
  output logic                            init_done,
  output logic                            ram_rw,
  output logic [3:0]                      ram_cs,
  output logic [AddressDepth-1:0]         ram_addr,
  output logic [DataWide-1:0]             ram_din,
  input  logic [DataWide-1:0]             ram_dout
);

  arb_state_e                r_state;
  arb_state_e                w_state_next;
  logic                      r_grant;
  logic                      r_we;
  logic [AddressDepth-1:0]   r_addr;
  logic [DataWide-1:0]       r_wdata;
  logic [DataWide-1:0]       r_rdata;
  logic                      r_init_done;

  logic                      w_grant_valid;
  logic                      w_grant_idx;
  logic                      w_grant_stb;
  logic                      w_clr_last;
  logic [AddressDepth-1:0]   w_clr_addr;

  logic [AddressDepth-1:0]   w_addr_arr  [NUM_REQ];
  logic [DataWide-1:0]       w_wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_client
      assign w_addr_arr[gi]  = addr[gi*AddressDepth +: AddressDepth];
      assign w_wdata_arr[gi] = wdata[gi*DataWide +: DataWide];
      assign ack[gi]         = (r_state == DONE) && (r_grant == 1'(gi));
    end
  endgenerate

`ifdef RAM_INIT_CLEAR_EN
  localparam arb_state_e RESET_STATE = CLEAR;

  logic [AddressDepth-1:0] r_clr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clr_cnt <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  assign w_clr_last = (r_clr_cnt == AddressDepth'(RAM_WORDS - 1));
  assign w_clr_addr = r_clr_cnt;
`else
  localparam arb_state_e RESET_STATE = IDLE;

  assign w_clr_last = 1'b1;
  assign w_clr_addr = '0;
`endif

  // Requests raised while clearing stay pending: arbitration happens only in IDLE.
  assign w_grant_stb = (r_state == IDLE) && w_grant_valid;

  ram_rr_picker u_picker (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (req),
    .i_grant_stb   (w_grant_stb),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_state_next = ISSUE;
      ISSUE:   w_state_next = RESP;
      RESP:    w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      CLEAR:   if (w_clr_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RESET_STATE;
      r_grant     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_stb) begin
        r_grant <= w_grant_idx;
        r_we    <= we[w_grant_idx];
        r_addr  <= w_addr_arr[w_grant_idx];
        r_wdata <= w_wdata_arr[w_grant_idx];
      end
      // The RAM drives ram_dout only in the cycle after a read issue.
      if ((r_state == RESP) && !r_we) begin
        r_rdata <= ram_dout;
      end
      if (w_state_next != CLEAR) begin
        r_init_done <= 1'b1;
      end
    end
  end

  always_comb begin
    ram_cs   = CS_OFF;
    ram_rw   = 1'b0;
    ram_addr = r_addr;
    ram_din  = r_wdata;
    case (r_state)
      ISSUE: begin
        ram_cs = CS_SEL;
        ram_rw = r_we;
      end
      CLEAR: begin
        ram_cs   = CS_SEL;
        ram_rw   = 1'b1;
        ram_addr = w_clr_addr;
        ram_din  = '0;
      end
      default: ;
    endcase
  end

  assign rdata     = r_rdata;
  assign busy      = (r_state != IDLE);
  assign init_done = r_init_done;

endmodule

// File: tb/tb_ram_w16b8_arbiter.sv
// Directed bench for ram_w16b8_arbiter with a behavioural 16x8 synchronous RAM.
module tb_ram_w16b8_arbiter;

`ifdef RAM_INIT_CLEAR_EN
  localparam bit CLR_MODE = 1'b1;
`else
  localparam bit CLR_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        busy;
  logic        init_done;
  logic        ram_rw;
  logic [3:0]  ram_cs;
  logic [3:0]  ram_addr;
  logic [7:0]  ram_din;
  wire  [7:0]  ram_dout;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_w16b8_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .init_done (init_done),
    .ram_rw    (ram_rw),
    .ram_cs    (ram_cs),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // 16x8 RAM: acts on the closing edge of a selected cycle, read data valid one cycle later.
  logic [7:0] mem [16];
  logic [7:0] rd_q = 8'h00;
  logic       rd_v = 1'b0;

  always @(posedge clk) begin
    rd_v <= 1'b0;
    if (ram_cs == 4'hF) begin
      if (ram_rw) begin
        mem[ram_addr] <= ram_din;
      end else begin
        rd_q <= mem[ram_addr];
        rd_v <= 1'b1;
      end
    end
  end

  assign ram_dout = rd_v ? rd_q : 8'hzz;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int c, input logic w, input logic [3:0] a, input logic [7:0] d);
    we[c]          = w;
    addr[c*4 +: 4] = a;
    wdata[c*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 40 && !init_done; i++) step();
    check_vec("reinit_done", 32'(init_done), 32'd1);
    check_vec("reinit_rdata", 32'(rdata), 32'h00);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) step();
    check_vec("wait_idle", 32'(busy), 32'd0);
  endtask

  // Single uncontested transaction from IDLE with exact cycle-by-cycle expectations.
  task automatic txn_exact(input int c, input logic w, input logic [3:0] a,
                           input logic [7:0] d, input logic [7:0] exp_rd);
    set_client(c, w, a, d);
    req[c] = 1'b1;
    step();
    check_vec("issue_cs", 32'(ram_cs), 32'hF);
    check_vec("issue_rw", 32'(ram_rw), 32'(w));
    check_vec("issue_addr", 32'(ram_addr), 32'(a));
    if (w) check_vec("issue_din", 32'(ram_din), 32'(d));
    step();
    check_vec("resp_cs", 32'(ram_cs), 32'h0);
    check_vec("resp_ack", 32'(ack), 32'd0);
    step();
    check_vec("done_ack", 32'(ack), 32'(1 << c));
    if (!w) check_vec("done_rdata", 32'(rdata), 32'(exp_rd));
    req[c] = 1'b0;
    $display("txn client=%0d %s addr=%h data=%h rdata=%h", c, w ? "WR" : "RD", a, d, rdata);
    step();
    check_vec("post_ack", 32'(ack), 32'd0);
    check_vec("post_busy", 32'(busy), 32'd0);
  endtask

  // Both clients read at once; verifies service order and per-client read data.
  task automatic serve_both(input logic [3:0] a0, input logic [3:0] a1, input int exp_first,
                            input logic [7:0] exp0, input logic [7:0] exp1);
    int order[2];
    int n;
    order[0] = -1;
    order[1] = -1;
    n = 0;
    set_client(0, 1'b0, a0, 8'h00);
    set_client(1, 1'b0, a1, 8'h00);
    req = 2'b11;
    for (int i = 0; i < 24 && n < 2; i++) begin
      step();
      for (int c = 0; c < 2; c++) begin
        if (ack[c] && n < 2) begin
          order[n] = c;
          n++;
          req[c] = 1'b0;
          check_vec($sformatf("pair_rdata%0d", c), 32'(rdata), 32'(c == 0 ? exp0 : exp1));
          $display("txn client=%0d RD addr=%h rdata=%h (pair)", c, c == 0 ? a0 : a1, rdata);
        end
      end
    end
    req = 2'b00;
    check_vec("pair_count", 32'(n), 32'd2);
    check_vec("pair_first", 32'(order[0]), 32'(exp_first));
    check_vec("pair_second", 32'(order[1]), 32'(1 - exp_first));
    step();
    wait_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack0_cyc[4];
    int n0;
    int t_raise;
    int ack1_cyc;
    bit got1;
    bit done6;

    rst_n = 1'b0;
    req   = 2'b00;
    we    = 2'b00;
    addr  = 8'h00;
    wdata = 16'h0000;
    step();
    step();
    step();

    check_vec("rst_ack", 32'(ack), 32'd0);
    check_vec("rst_rdata", 32'(rdata), 32'h00);
    check_vec("rst_busy", 32'(busy), 32'(CLR_MODE));
    check_vec("rst_cs", 32'(ram_cs), CLR_MODE ? 32'hF : 32'h0);
    check_vec("rst_rw", 32'(ram_rw), 32'(CLR_MODE));
    check_vec("rst_addr", 32'(ram_addr), 32'h0);
    check_vec("rst_din", 32'(ram_din), 32'h00);
    check_vec("rst_init_done", 32'(init_done), 32'd0);

`ifdef RAM_INIT_CLEAR_EN
    // Client 1 read of addr 9 raised during CLEAR must wait for the zeroing pass.
    rst_n = 1'b1;
    set_client(1, 1'b0, 4'h9, 8'h00);
    req[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_vec("clr_cs", 32'(ram_cs), 32'hF);
      check_vec("clr_rw", 32'(ram_rw), 32'd1);
      check_vec("clr_addr", 32'(ram_addr), 32'(i));
      check_vec("clr_din", 32'(ram_din), 32'h00);
      check_vec("clr_init", 32'(init_done), 32'd0);
      check_vec("clr_ack", 32'(ack), 32'd0);
      step();
    end
    check_vec("clr_end_init", 32'(init_done), 32'd1);
    check_vec("clr_end_busy", 32'(busy), 32'd0);
    step();
    step();
    step();
    check_vec("clr_pend_ack", 32'(ack), 32'b10);
    check_vec("clr_pend_rdata", 32'(rdata), 32'h00);
    $display("txn client=1 RD addr=9 rdata=%h (held through clear)", rdata);
    req = 2'b00;
    step();
`else
    rst_n = 1'b1;
    step();
    check_vec("init_done", 32'(init_done), 32'd1);
    check_vec("idle_busy", 32'(busy), 32'd0);
`endif

    // Write then read back through client 0.
    txn_exact(0, 1'b1, 4'h3, 8'hA5, 8'h00);
    txn_exact(0, 1'b0, 4'h3, 8'h00, 8'hA5);

    // Top address, then rdata must hold across a write and idle cycles.
    txn_exact(1, 1'b1, 4'hF, 8'h3C, 8'h00);
    txn_exact(1, 1'b0, 4'hF, 8'h00, 8'h3C);
    txn_exact(0, 1'b1, 4'h3, 8'h77, 8'h00);
    check_vec("hold_after_wr", 32'(rdata), 32'h3C);
    for (int i = 0; i < 3; i++) begin
      step();
      check_vec("hold_idle", 32'(rdata), 32'h3C);
    end

    // Fresh pointer after reset: first contested pair goes to client 0, the next to client 1.
    do_reset();
    txn_exact(0, 1'b1, 4'h1, 8'h11, 8'h00);
    txn_exact(1, 1'b1, 4'h2, 8'h22, 8'h00);
    serve_both(4'h1, 4'h2, 0, 8'h11, 8'h22);
    serve_both(4'h1, 4'h2, 1, 8'h11, 8'h22);

    // Client 0 streams reads; client 1 joins after the third ack and must be served.
    n0       = 0;
    t_raise  = 0;
    ack1_cyc = 0;
    got1     = 1'b0;
    done6    = 1'b0;
    set_client(0, 1'b0, 4'h1, 8'h00);
    req[0] = 1'b1;
    for (int i = 0; i < 60 && !done6; i++) begin
      step();
      if (ack[0]) begin
        if (n0 < 4) ack0_cyc[n0] = cyc;
        n0++;
        check_vec("stream_rdata0", 32'(rdata), 32'h11);
        $display("txn client=0 RD addr=1 rdata=%h (stream)", rdata);
        if (n0 == 3) begin
          set_client(1, 1'b0, 4'h2, 8'h00);
          req[1] = 1'b1;
          t_raise = cyc;
        end
        if (got1) begin
          req[0] = 1'b0;
          done6 = 1'b1;
        end
      end
      if (ack[1]) begin
        ack1_cyc = cyc;
        got1 = 1'b1;
        req[1] = 1'b0;
        check_vec("stream_rdata1", 32'(rdata), 32'h22);
        $display("txn client=1 RD addr=2 rdata=%h (joined stream)", rdata);
      end
    end
    req = 2'b00;
    check_vec("stream_done", 32'(done6), 32'd1);
    check_vec("stream_gap01", 32'(ack0_cyc[1] - ack0_cyc[0]), 32'd4);
    check_vec("stream_gap12", 32'(ack0_cyc[2] - ack0_cyc[1]), 32'd4);
    check_vec("stream_gap23", 32'(ack0_cyc[3] - ack0_cyc[2]), 32'd4);
    check_vec("no_starve_c1", 32'(ack1_cyc - t_raise), 32'd8);
    step();
    wait_idle();

    // Reset asserted during the RESP cycle of a read.
    check_vec("pre_rst_rdata", 32'(rdata), 32'h11);
    set_client(0, 1'b0, 4'h2, 8'h00);
    req[0] = 1'b1;
    step();
    check_vec("mid_issue_cs", 32'(ram_cs), 32'hF);
    step();
    check_vec("mid_resp_cs", 32'(ram_cs), 32'h0);
    rst_n = 1'b0;
    req   = 2'b00;
    step();
    check_vec("mid_rst_ack", 32'(ack), 32'd0);
    check_vec("mid_rst_rdata", 32'(rdata), 32'h00);
    check_vec("mid_rst_busy", 32'(busy), 32'(CLR_MODE));
    rst_n = 1'b1;
    step();
    check_vec("mid_rst_ack2", 32'(ack), 32'd0);
    $display("txn client=0 RD addr=2 aborted by reset rdata=%h", rdata);
    for (int i = 0; i < 40 && !init_done; i++) step();
    check_vec("mid_rst_init", 32'(init_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
